// File: rtl/vx_tensor_dpu_arbiter_if.sv
// Requester, DPU-issue, DPU-result and per-requester result handshakes of the tensor DPU arbiter.
// slave is the arbiter's view; master is the view of the surrounding core/DPU.
interface vx_tensor_dpu_arbiter_if #(
  parameter int NUM_REQS  = 2,
  parameter int REQ_DATAW = 1024,
  parameter int RSP_DATAW = 512,
  parameter int NW_WIDTH  = 4
);
  logic [NUM_REQS-1:0]           req_valid;
  logic [NUM_REQS-1:0]           req_ready;
  logic [NUM_REQS*REQ_DATAW-1:0] req_data;
  logic [NUM_REQS*NW_WIDTH-1:0]  req_wid;

  logic                          dpu_valid_in;
  logic                          dpu_ready_in;
  logic [REQ_DATAW-1:0]          dpu_data;
  logic [NW_WIDTH-1:0]           dpu_wid;

  logic                          dpu_valid_out;
  logic                          dpu_ready_out;
  logic [RSP_DATAW-1:0]          dpu_rsp_data;
  logic [NW_WIDTH-1:0]           dpu_rsp_wid;

  logic [NUM_REQS-1:0]           rsp_valid;
  logic [NUM_REQS-1:0]           rsp_ready;
  logic [RSP_DATAW-1:0]          rsp_data;
  logic [NW_WIDTH-1:0]           rsp_wid;

  modport slave (
    input  req_valid, req_data, req_wid, dpu_ready_in,
    input  dpu_valid_out, dpu_rsp_data, dpu_rsp_wid, rsp_ready,
    output req_ready, dpu_valid_in, dpu_data, dpu_wid,
    output dpu_ready_out, rsp_valid, rsp_data, rsp_wid
  );

  modport master (
    output req_valid, req_data, req_wid, dpu_ready_in,
    output dpu_valid_out, dpu_rsp_data, dpu_rsp_wid, rsp_ready,
    input  req_ready, dpu_valid_in, dpu_data, dpu_wid,
    input  dpu_ready_out, rsp_valid, rsp_data, rsp_wid
  );
endinterface

// File: rtl/vx_tensor_dpu_arbiter.sv
// Round-robin share of one tensor DPU: credit-capped issue, issue-order tag FIFO, drain FSM.
// Zero added latency; issue stalls on DPU/credits/drain, results stall on the head requester's rsp_ready.

module vx_tensor_dpu_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (occ == '0);
  assign full  = (occ == CW'(DEPTH));
endmodule

module vx_tensor_dpu_arbiter #(
  parameter  int NUM_REQS     = 2,
  parameter  int REQ_DATAW    = 1024,
  parameter  int RSP_DATAW    = 512,
  parameter  int MAX_INFLIGHT = 8,
  parameter  int NW_WIDTH     = 4,
  localparam int REQW         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CNTW         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_tensor_dpu_arbiter_if.slave bus,
  input  logic                 drain_req,
  output logic                 drained,
  output logic [CNTW-1:0]      inflight,
  output logic                 err_rsp
);
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  logic [1:0]      state;
  logic [CNTW-1:0] count;
  logic [REQW-1:0] grant, head;
  logic            issue_ok, issue_fire, ret_fire, tag_empty, tag_full;

  // reset_n gates issue so nothing is offered to either side while held in reset
  assign issue_ok = reset_n && (state == ST_RUN) && !drain_req &&
                    (count < CNTW'(MAX_INFLIGHT)) && !tag_full;

  generate
    if (NUM_REQS == 1) begin : g_single
      assign grant = '0;
    end else begin : g_rr
      logic [REQW-1:0] rr_ptr;

      always_comb begin
        logic found;
        int   idx;
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
          idx = (int'(rr_ptr) + k) % NUM_REQS;
          if (!found && bus.req_valid[REQW'(idx)]) begin
            grant = REQW'(idx);
            found = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        rr_ptr <= '0;
        else if (issue_fire) rr_ptr <= (grant == REQW'(NUM_REQS - 1)) ? '0 : grant + REQW'(1);
      end
    end
  endgenerate

  assign bus.dpu_valid_in = issue_ok && (|bus.req_valid);
  assign bus.dpu_data     = bus.req_data[grant*REQ_DATAW +: REQ_DATAW];
  assign bus.dpu_wid      = bus.req_wid[grant*NW_WIDTH +: NW_WIDTH];
  assign bus.req_ready    = NUM_REQS'(issue_ok && bus.dpu_ready_in) << grant;
  assign issue_fire       = bus.dpu_valid_in && bus.dpu_ready_in;

  vx_tensor_dpu_tag_fifo #(
    .WIDTH (REQW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (issue_fire),
    .din     (grant),
    .pop     (ret_fire),
    .dout    (head),
    .empty   (tag_empty),
    .full    (tag_full)
  );

  // DPU returns in issue order, so the FIFO head names the owner of the current result
  assign bus.rsp_valid     = NUM_REQS'(bus.dpu_valid_out && !tag_empty) << head;
  assign bus.dpu_ready_out = !tag_empty && (|(bus.rsp_ready & (NUM_REQS'(1) << head)));
  assign bus.rsp_data      = bus.dpu_rsp_data;
  assign bus.rsp_wid       = bus.dpu_rsp_wid;
  assign ret_fire          = bus.dpu_valid_out && bus.dpu_ready_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      state   <= ST_RUN;
      err_rsp <= 1'b0;
    end else begin
      count <= count + CNTW'(issue_fire) - CNTW'(ret_fire);
      if (bus.dpu_valid_out && tag_empty) err_rsp <= 1'b1;
      case (state)
        ST_RUN:     if (drain_req) state <= ST_DRAIN;
        ST_DRAIN:   if ((count == '0) && !issue_fire) state <= ST_DRAINED;
        ST_DRAINED: if (!drain_req) state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  assign drained  = (state == ST_DRAINED);
  assign inflight = count;
endmodule

// File: tb/tb_vx_tensor_dpu_arbiter.sv
// Bench for vx_tensor_dpu_arbiter: constant vector table, directed corner sequences and a
// randomized run against a queue-based reference model of issue order, credits and drain.
module tb_vx_tensor_dpu_arbiter;
  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int RW   = 16;
  localparam int NW   = 4;
  localparam int MAXI = 8;
  localparam int CNTW = $clog2(MAXI + 1);

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            drain_req = 1'b0;
  logic            drained, err_rsp;
  logic [CNTW-1:0] inflight;

  vx_tensor_dpu_arbiter_if #(.NUM_REQS(N), .REQ_DATAW(DW), .RSP_DATAW(RW), .NW_WIDTH(NW)) bus ();

  vx_tensor_dpu_arbiter #(
    .NUM_REQS(N), .REQ_DATAW(DW), .RSP_DATAW(RW), .MAX_INFLIGHT(MAXI), .NW_WIDTH(NW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .drain_req (drain_req),
    .drained   (drained),
    .inflight  (inflight),
    .err_rsp   (err_rsp)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rdat [N];
  logic [NW-1:0] rwid [N];

  // reference model: issue-order queue of requester ids, rr pointer, drain mode, sticky error
  int tagq[$];
  int mrr;
  int mstate;   // 0 running, 1 draining, 2 drained
  bit merr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [N-1:0] rv;
    logic         rdy;
    logic         exp_vld;
    logic [N-1:0] exp_rdy;
    int           exp_g;
    int           exp_cnt;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*DW +: DW] = rdat[i];
      bus.req_wid[i*NW +: NW]  = rwid[i];
    end
  endtask

  function automatic int grant_of(input logic [N-1:0] rv);
    for (int k = 0; k < N; k++)
      if (rv[(mrr + k) % N]) return (mrr + k) % N;
    return -1;
  endfunction

  task automatic set_in(input logic [N-1:0] rv, input logic rdy, input logic dvo, input logic [N-1:0] rr);
    bus.req_valid     = rv;
    bus.dpu_ready_in  = rdy;
    bus.dpu_valid_out = dvo;
    bus.rsp_ready     = rr;
    pack();
  endtask

  // one clock: compare every output to the model, then advance the model with the edge
  task automatic cycle();
    int g, head, sz;
    bit ok, any, ev, er, ifire, rfire, dvo, drq;
    logic [N-1:0] ersp, erdy;
    pack();
    #1;
    sz   = tagq.size();
    ok   = (mstate == 0) && !drain_req && (sz < MAXI);
    any  = |bus.req_valid;
    g    = grant_of(bus.req_valid);
    ev   = ok && any;
    chk("dpu_valid_in", 64'(bus.dpu_valid_in), 64'(ev));
    if (any) begin
      erdy = (ok && bus.dpu_ready_in) ? (N'(1) << g) : '0;
      chk("req_ready", 64'(bus.req_ready), 64'(erdy));
    end
    if (ev) begin
      chk("dpu_data", 64'(bus.dpu_data), 64'(rdat[g]));
      chk("dpu_wid", 64'(bus.dpu_wid), 64'(rwid[g]));
    end
    head = (sz > 0) ? tagq[0] : -1;
    dvo  = bus.dpu_valid_out;
    drq  = drain_req;
    ersp = (dvo && head >= 0) ? (N'(1) << head) : '0;
    er   = (head >= 0) && (((bus.rsp_ready >> head) & N'(1)) != '0);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(ersp));
    chk("dpu_ready_out", 64'(bus.dpu_ready_out), 64'(er));
    if (dvo) chk("rsp_data", 64'(bus.rsp_data), 64'(bus.dpu_rsp_data));
    chk("inflight", 64'(inflight), 64'(sz));
    chk("drained", 64'(drained), 64'(mstate == 2));
    chk("err_rsp", 64'(err_rsp), 64'(merr));
    ifire = ev && bus.dpu_ready_in;
    rfire = dvo && er;
    @(posedge clk);
    if (dvo && sz == 0) merr = 1'b1;
    if (rfire) void'(tagq.pop_front());
    if (ifire) begin
      tagq.push_back(g);
      mrr = (g + 1) % N;
    end
    case (mstate)
      0: if (drq) mstate = 1;
      1: if (sz == 0 && !ifire) mstate = 2;
      default: if (!drq) mstate = 0;
    endcase
    #1;
  endtask

  task automatic drain_all(input string name);
    for (int k = 0; k < 40 && tagq.size() > 0; k++) begin
      set_in('0, 1'b1, 1'b1, '1);
      cycle();
    end
    set_in('0, 1'b1, 1'b0, '1);
    chk({name, "_empty"}, 64'(inflight), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int exp_seq [3];
    tbl[0]  = '{2'b11, 1'b1, 1'b1, 2'b01, 0, 0};
    tbl[1]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1, 1};
    tbl[2]  = '{2'b10, 1'b1, 1'b1, 2'b10, 1, 2};
    tbl[3]  = '{2'b01, 1'b0, 1'b1, 2'b00, 0, 3};
    tbl[4]  = '{2'b10, 1'b0, 1'b1, 2'b00, 1, 3};
    tbl[5]  = '{2'b11, 1'b1, 1'b1, 2'b01, 0, 3};
    tbl[6]  = '{2'b01, 1'b1, 1'b1, 2'b01, 0, 4};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1, 5};
    tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b01, 0, 6};
    tbl[9]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1, 7};
    tbl[10] = '{2'b11, 1'b1, 1'b0, 2'b00, 0, 8};
    exp_seq = '{2, 1, 1};

    for (int i = 0; i < N; i++) begin
      rdat[i] = DW'(16'hA0A0 + i * 16'h0101);
      rwid[i] = NW'(i + 3);
    end
    bus.dpu_rsp_data = 16'h5A5A;
    bus.dpu_rsp_wid  = 4'h7;
    tagq.delete(); mrr = 0; mstate = 0; merr = 1'b0;

    // reset holds every output low even with live inputs
    set_in(2'b11, 1'b1, 1'b1, 2'b11);
    #2;
    chk("rst_dpu_valid_in", 64'(bus.dpu_valid_in), 0);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_dpu_ready_out", 64'(bus.dpu_ready_out), 0);
    chk("rst_drained", 64'(drained), 0);
    chk("rst_inflight", 64'(inflight), 0);
    chk("rst_err", 64'(err_rsp), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    set_in('0, 1'b1, 1'b0, 2'b11);

    // arbitration table up to the credit cap
    foreach (tbl[i]) begin
      set_in(tbl[i].rv, tbl[i].rdy, 1'b0, 2'b11);
      #1;
      chk($sformatf("tbl%0d_vld", i), 64'(bus.dpu_valid_in), 64'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_rdy", i), 64'(bus.req_ready), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_cnt", i), 64'(inflight), 64'(tbl[i].exp_cnt));
      if (tbl[i].exp_vld) chk($sformatf("tbl%0d_grant", i), 64'(bus.dpu_data), 64'(rdat[tbl[i].exp_g]));
      cycle();
    end

    // at the cap: return alone, then return+issue together keeps count, then issue refills
    set_in(2'b01, 1'b1, 1'b1, 2'b11);
    #1;
    chk("cap_vld", 64'(bus.dpu_valid_in), 0);
    chk("cap_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
    cycle();
    chk("cap_ret_cnt", 64'(inflight), 7);
    set_in(2'b01, 1'b1, 1'b1, 2'b11);
    #1;
    chk("cap_both_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
    cycle();
    chk("cap_both_cnt", 64'(inflight), 7);
    set_in(2'b01, 1'b1, 1'b0, 2'b11);
    cycle();
    chk("cap_refill_cnt", 64'(inflight), 8);
    #1;
    chk("cap_refill_rdy", 64'(bus.req_ready), 0);
    drain_all("cap");

    // result backpressure from requester 1 holds requester 0's results behind it
    set_in(2'b10, 1'b1, 1'b0, 2'b11); cycle();
    set_in(2'b01, 1'b1, 1'b0, 2'b11); cycle();
    set_in(2'b01, 1'b1, 1'b0, 2'b11); cycle();
    for (int k = 0; k < 3; k++) begin
      set_in('0, 1'b1, 1'b1, 2'b01);
      #1;
      chk("bp_ready_out", 64'(bus.dpu_ready_out), 0);
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
      cycle();
    end
    chk("bp_hold_cnt", 64'(inflight), 3);
    for (int k = 0; k < 3; k++) begin
      set_in('0, 1'b1, 1'b1, 2'b11);
      #1;
      chk($sformatf("bp_order%0d", k), 64'(bus.rsp_valid), 64'(exp_seq[k]));
      cycle();
    end
    set_in('0, 1'b1, 1'b0, 2'b11);
    chk("bp_done_cnt", 64'(inflight), 0);

    // drain with 5 in flight; rr pointer survives the drain
    for (int k = 0; k < 5; k++) begin
      set_in(2'b01, 1'b1, 1'b0, 2'b11); cycle();
    end
    drain_req = 1'b1;
    set_in(2'b11, 1'b1, 1'b0, 2'b11);
    #1;
    chk("drn_block_vld", 64'(bus.dpu_valid_in), 0);
    chk("drn_block_rdy", 64'(bus.req_ready), 0);
    cycle(); cycle();
    chk("drn_wait", 64'(drained), 0);
    for (int k = 0; k < 5; k++) begin
      set_in(2'b11, 1'b1, 1'b1, 2'b11); cycle();
    end
    set_in(2'b11, 1'b1, 1'b0, 2'b11);
    chk("drn_after_last_ret", 64'(drained), 0);
    cycle();
    chk("drn_drained", 64'(drained), 1);
    drain_req = 1'b0;
    #1;
    chk("drn_still_blocked", 64'(bus.dpu_valid_in), 0);
    cycle();
    #1;
    chk("drn_resume_vld", 64'(bus.dpu_valid_in), 1);
    chk("drn_resume_grant", 64'(bus.dpu_data), 64'(rdat[1]));
    cycle();
    drain_all("drn");

    // drain entered with nothing in flight takes one DRAIN cycle
    drain_req = 1'b1;
    set_in('0, 1'b1, 1'b0, 2'b11);
    cycle();
    chk("drn0_one", 64'(drained), 0);
    cycle();
    chk("drn0_two", 64'(drained), 1);
    drain_req = 1'b0;
    cycle();

    // steady stream: both valid, results 4 cycles later
    start = mrr;
    for (int k = 0; k < 20; k++) begin
      set_in(2'b11, 1'b1, (k >= 4), 2'b11);
      #1;
      chk($sformatf("str_grant%0d", k), 64'(bus.dpu_data), 64'(rdat[(start + k) % N]));
      if (k >= 4) chk($sformatf("str_cnt%0d", k), 64'(inflight), 4);
      cycle();
    end
    drain_all("str");

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        rdat[i] = DW'($urandom);
        rwid[i] = NW'($urandom);
      end
      bus.dpu_rsp_data = RW'($urandom);
      bus.dpu_rsp_wid  = NW'($urandom);
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      set_in(N'($urandom), ($urandom_range(0, 3) != 0),
             (tagq.size() > 0) && ($urandom_range(0, 1) == 1), N'($urandom));
      cycle();
    end
    drain_req = 1'b0;
    drain_all("rnd");

    // reset in the middle of traffic
    set_in('0, 1'b1, 1'b0, 2'b11);
    cycle(); cycle();
    for (int k = 0; k < 3; k++) begin
      set_in(2'b01, 1'b1, 1'b0, 2'b11); cycle();
    end
    chk("mid_cnt", 64'(inflight), 3);
    set_in(2'b11, 1'b1, 1'b1, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(bus.dpu_valid_in), 0);
    chk("mid_rst_rdy", 64'(bus.req_ready), 0);
    chk("mid_rst_rsp", 64'(bus.rsp_valid), 0);
    chk("mid_rst_cnt", 64'(inflight), 0);
    @(posedge clk); #1;
    chk("mid_rst_edge_rsp", 64'(bus.rsp_valid), 0);
    chk("mid_rst_edge_ready_out", 64'(bus.dpu_ready_out), 0);
    reset_n = 1'b1;
    tagq.delete(); mrr = 0; mstate = 0; merr = 1'b0;
    set_in('0, 1'b1, 1'b0, 2'b11);
    cycle();

    // orphan result sets the sticky error
    set_in('0, 1'b1, 1'b1, 2'b11);
    #1;
    chk("err_ready_out", 64'(bus.dpu_ready_out), 0);
    chk("err_before", 64'(err_rsp), 0);
    cycle();
    set_in('0, 1'b1, 1'b0, 2'b11);
    chk("err_set", 64'(err_rsp), 1);
    set_in(2'b01, 1'b1, 1'b0, 2'b11); cycle();
    drain_all("err");
    cycle(); cycle();
    chk("err_sticky", 64'(err_rsp), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
